// File: rtl/eval_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : eval_channel_arbiter
// Purpose  : Round-robin, packet-locked arbiter multiplexing N valid/ready
//            requesters onto one shared output channel.
// Revision : 1.0 - initial release
// ============================================================================
module eval_channel_arbiter #(
    parameter  int N         = 4,
    parameter  int W         = 32,
    parameter  int MAX_BEATS = 16,
    localparam int SEL_W     = $clog2(N),
    localparam int CNT_W     = $clog2(MAX_BEATS) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_last,
    output logic [SEL_W-1:0] out_sel,
    output logic             busy,
    output logic             err_overlong
);

    localparam int CAND_W = SEL_W + 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   lock_idx_q, lock_idx_d;
    logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               err_q, err_d;

    logic [SEL_W-1:0]   winner;
    logic [CAND_W-1:0]  cand;
    logic               found;
    logic               fire;

    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
        next_idx = (idx == SEL_W'(N - 1)) ? '0 : idx + SEL_W'(1);
    endfunction

    // Rotating priority search starting at rr_ptr; explicit wrap keeps
    // non-power-of-two N correct.
    always_comb begin
        winner = rr_ptr_q;
        found  = 1'b0;
        cand   = '0;
        if (state_q == ST_LOCKED) begin
            winner = lock_idx_q;
        end else begin
            for (int k = 0; k < N; k++) begin
                cand = {1'b0, rr_ptr_q} + CAND_W'(k);
                if (cand >= CAND_W'(N)) begin
                    cand = cand - CAND_W'(N);
                end
                if (!found && in_valid[cand[SEL_W-1:0]]) begin
                    winner = cand[SEL_W-1:0];
                    found  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (rst_n) begin
            in_ready[winner] = out_ready;
        end
    end

    assign out_valid    = rst_n & in_valid[winner];
    assign out_data     = in_data[winner*W +: W];
    assign out_last     = in_last[winner];
    assign out_sel      = winner;
    assign busy         = (state_q == ST_LOCKED);
    assign err_overlong = err_q;
    assign fire         = out_valid & out_ready;

    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (out_valid) begin
                    if (fire && out_last) begin
                        rr_ptr_d = next_idx(winner);
                    end else begin
                        state_d    = ST_LOCKED;
                        lock_idx_d = winner;
                    end
                end
            end
            ST_LOCKED: begin
                if (fire && out_last) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_idx(lock_idx_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The overlong flag only reports; the packet still runs to its last beat.
        if (fire) begin
            if (out_last) begin
                beat_cnt_d = '0;
            end else begin
                if (beat_cnt_q != CNT_W'(MAX_BEATS)) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
                if (beat_cnt_q == CNT_W'(MAX_BEATS - 1)) begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

endmodule
`default_nettype wire
